// File: rtl/bf16_pkg.sv
// Shared encodings and constants for the FP32/BF16 conversion datapath.
package bf16_pkg;

    typedef logic [3:0] fflags_t;

    localparam logic OP_BF16_TO_FP32 = 1'b0;
    localparam logic OP_FP32_TO_BF16 = 1'b1;

    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    localparam int unsigned FLAG_NV = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    localparam logic [15:0] QNAN_BF16 = 16'h7FC0;
    localparam logic [7:0]  EXP_MAX   = 8'hFF;

endpackage

// File: rtl/bf16_lane_cvt.sv
// Combinational single-lane FP32<->BF16 converter with IEEE exception flags.
module bf16_lane_cvt
    import bf16_pkg::*;
(
    input  logic        op_i,
    input  logic        rnd_i,
    input  logic [31:0] operand_i,
    output logic [31:0] result_o,
    output fflags_t     flags_o
);

    logic [7:0]  exp32;
    logic [22:0] man32;
    logic [15:0] bf_in;
    logic        nx;
    logic        rne_carry;
    logic [15:0] bf_rnd;

    assign exp32 = operand_i[30:23];
    assign man32 = operand_i[22:0];
    assign bf_in = operand_i[15:0];
    assign nx    = |operand_i[15:0];

    // Adding 0x7FFF + lsb to the word carries into the upper half exactly when low + lsb > 0x8000.
    assign rne_carry = ({1'b0, operand_i[15:0]} + {16'b0, operand_i[16]}) > 17'h08000;
    assign bf_rnd    = (rnd_i == RND_RNE) ? operand_i[31:16] + {15'b0, rne_carry}
                                          : operand_i[31:16];

    always_comb begin
        result_o = '0;
        flags_o  = '0;
        if (op_i == OP_FP32_TO_BF16) begin
            if (exp32 == EXP_MAX && man32 != '0) begin
                result_o[15:0]   = QNAN_BF16;
                flags_o[FLAG_NV] = ~man32[22];
            end else if (exp32 == EXP_MAX || operand_i[30:0] == '0) begin
                result_o[15:0] = operand_i[31:16];
            end else begin
                result_o[15:0]   = bf_rnd;
                flags_o[FLAG_NX] = nx;
                flags_o[FLAG_OF] = (bf_rnd[14:7] == EXP_MAX);
                flags_o[FLAG_UF] = (bf_rnd[14:7] == 8'h00) && nx;
            end
        end else begin
            if (bf_in[14:7] == EXP_MAX && bf_in[6:0] != '0 && !bf_in[6]) begin
                result_o         = {bf_in | 16'h0040, 16'h0000};
                flags_o[FLAG_NV] = 1'b1;
            end else begin
                result_o = {bf_in, 16'h0000};
            end
        end
    end

endmodule

// File: rtl/bf16_convert_pipe.sv
// Multi-lane pipelined FP32<->BF16 converter with valid/ready flow control and sticky flags.
module bf16_convert_pipe
    import bf16_pkg::*;
#(
    parameter int unsigned LANES       = 2,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op,
    input  logic                  rnd,
    input  logic [32*LANES-1:0]   operand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*LANES-1:0]   result,
    output logic [3:0]            flags,
    output logic [3:0]            fpcsr,
    input  logic                  clear_flags
);

    localparam int unsigned W = 32 * LANES;

    logic [W-1:0]            cvt_res;
    fflags_t [LANES-1:0]     lane_flags;
    fflags_t                 cvt_flags;

    logic [PIPE_STAGES-1:0]  valid_q;
    logic [W-1:0]            data_q [PIPE_STAGES];
    fflags_t                 flag_q [PIPE_STAGES];
    fflags_t                 fpcsr_q;
    logic [PIPE_STAGES-1:0]  adv;
    logic                    deliver;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        bf16_lane_cvt u_lane (
            .op_i      (op),
            .rnd_i     (rnd),
            .operand_i (operand[32*i +: 32]),
            .result_o  (cvt_res[32*i +: 32]),
            .flags_o   (lane_flags[i])
        );
    end

    always_comb begin
        cvt_flags = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            cvt_flags = cvt_flags | lane_flags[i];
        end
    end

    // Ready ripples back from the output: a stage may load if it is empty or its successor moves.
    always_comb begin
        logic chain;
        adv   = '0;
        chain = out_ready || !valid_q[PIPE_STAGES-1];
        adv[PIPE_STAGES-1] = chain;
        for (int k = int'(PIPE_STAGES) - 2; k >= 0; k--) begin
            chain  = !valid_q[k] || chain;
            adv[k] = chain;
        end
    end

    assign deliver = valid_q[PIPE_STAGES-1] && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            fpcsr_q <= '0;
            for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
                data_q[k] <= '0;
                flag_q[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= cvt_res;
                    flag_q[0] <= cvt_flags;
                end
            end
            for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                        flag_q[k] <= flag_q[k-1];
                    end
                end
            end
            if (deliver) begin
                fpcsr_q <= (clear_flags ? '0 : fpcsr_q) | flag_q[PIPE_STAGES-1];
            end else if (clear_flags) begin
                fpcsr_q <= '0;
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[PIPE_STAGES-1];
    assign result    = data_q[PIPE_STAGES-1];
    assign flags     = flag_q[PIPE_STAGES-1];
    assign fpcsr     = fpcsr_q;

endmodule

// File: doc/bf16_convert_pipe.md
Name: bf16_convert_pipe

Overview:
Multi-lane, pipelined FP32<->BF16 format converter with valid/ready handshakes, a selectable rounding mode and sticky exception flags. It generalises the accelerator's single-operand conversion ops to LANES parallel lanes with backpressure. It sits beside the arithmetic units inside bf16_accelerator_top and feeds the fpcsr accumulation.

Parameters:
LANES, 2, number of parallel conversion lanes (1..8)
PIPE_STAGES, 2, register stages from input acceptance to output (1..4)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  converter can accept a beat this cycle
op  input  1  0 = BF16->FP32, 1 = FP32->BF16; sampled with the beat
rnd  input  1  0 = round-to-nearest-even, 1 = round-toward-zero; sampled with the beat
operand  input  32*LANES  lane i = bits [32i+31:32i]; BF16 input uses the low 16 bits of the lane
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
result  output  32*LANES  FP32 result, or {16'h0, bf16} per lane
flags  output  4  {NV,OF,UF,NX} for the current beat, ORed over lanes
fpcsr  output  4  sticky {NV,OF,UF,NX}
clear_flags  input  1  synchronous clear of fpcsr

Behaviour:
- Reset (async, any time): all stage valids = 0, out_valid = 0, result = 0, flags = 0, fpcsr = 0. In-flight beats are discarded. in_ready = 1 after reset is released.
- Handshakes:
  - A beat is accepted when in_valid && in_ready. It is delivered when out_valid && out_ready.
  - Stage k advances when it is empty or when stage k+1 advances. The last stage advances when out_ready || !out_valid.
  - in_ready = first stage advances.
- Latency and ordering:
  - With no stalls, a beat accepted at cycle t has out_valid asserted at t+PIPE_STAGES.
  - Throughput is 1 beat/cycle. Order is preserved.
  - Up to PIPE_STAGES beats may be held. Nothing is dropped or duplicated under any out_ready pattern.
- Output stability: while out_valid && !out_ready, result and flags hold stable.
- op and rnd travel with their beat. Mixed op/rnd across consecutive beats is legal.
- FP32->BF16, per lane, with x = lane[31:0]:
  - NaN: result 16'h7FC0 (canonical quiet NaN). NV set if sNaN (x[22] = 0). NX not set.
  - Inf and zero: truncated exactly, no flags.
  - RNE: add 16'h7FFF + x[16] to x, then take bits [31:16].
  - RTZ: take x[31:16].
  - NX set when x[15:0] != 0.
  - OF set (with NX) when a finite input rounds to an exponent of 8'hFF. RNE yields ±inf; RTZ never overflows and yields the maximum finite value.
  - UF set when the result exponent is 0 and NX is set. Subnormals are preserved, never flushed.
- BF16->FP32, per lane, with b = lane[15:0]:
  - Result = {b, 16'h0}, exact, no flags.
  - Exception: sNaN input. Result = {b | 16'h0040, 16'h0} and NV is set.
- flags = OR over all lanes of the beat's lane flags. It is valid only while out_valid.
- fpcsr updates on each delivered beat: fpcsr <= (clear_flags ? 0 : fpcsr) | flags.
  - Clear and a new delivery in the same cycle: the new flags survive.
  - clear_flags alone zeroes fpcsr on the next edge.

Decomposition:
- Shared package bf16_pkg holds:
  - op encoding: OP_BF16_TO_FP32 = 0, OP_FP32_TO_BF16 = 1.
  - rnd encoding: RND_RNE = 0, RND_RTZ = 1.
  - Flag bit indices: NV = 3, OF = 2, UF = 1, NX = 0.
  - Constants: QNAN_BF16 = 16'h7FC0, EXP_MAX = 8'hFF.
- Sub-module bf16_lane_cvt: combinational single-lane converter (op, rnd, 32-bit in -> 32-bit out, 4 flags). It is instantiated LANES times ahead of stage 1. The remaining stages are pure pipeline/handshake registers in bf16_convert_pipe.

Test Plan:
- FP32->BF16, RNE, lane0 = 32'h40490FDB, lane1 = 32'h3F818000 -> result lanes 32'h00004049, 32'h00003F82; flags = 4'b0001; out_valid exactly PIPE_STAGES cycles after acceptance.
- FP32->BF16 tie/overflow:
  - 32'h3F808000 RNE -> 16'h3F80, NX.
  - 32'h7F7FFFFF RNE -> 16'h7F80, flags 4'b0101.
  - 32'h7F7FFFFF RTZ -> 16'h7F7F, flags 4'b0001.
  - 32'h00010001 RNE -> 16'h0001, flags 4'b0011.
- NaN/specials:
  - FP32 32'h7F800001 -> 16'h7FC0, NV.
  - FP32 32'hFFC00000 -> 16'h7FC0, flags 0.
  - BF16 16'h3F80 -> 32'h3F800000, flags 0.
  - BF16 16'h7F81 -> 32'h7FC10000, NV.
  - BF16 16'h7F80 -> 32'h7F800000, flags 0.
- Backpressure: stream 6 beats, hold out_ready low for 5 cycles mid-stream -> in_ready drops after PIPE_STAGES beats are held; all 6 results arrive in order with no loss; result stable while stalled.
- Sticky flags: deliver an NX beat, then an NV beat -> fpcsr = 4'b1001. Assert clear_flags in the same cycle as an OF|NX delivery -> fpcsr = 4'b0101. clear_flags alone -> 0.
- Reset mid-stream: assert reset asynchronously (between clock edges) with 2 beats in flight -> out_valid, result, flags, fpcsr go to 0 immediately; no stale beat appears after release.
